// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
//   Bundles the byte streams and the program-memory write port used by the
//   boot loader.
//
//   Signals
//     rx_valid   UART RX -> loader   1-cycle pulse, rx_data valid
//     rx_data    UART RX -> loader   received byte
//     tx_data    loader  -> UART TX  byte to send, valid while tx_send is high
//     tx_send    loader  -> UART TX  1-cycle request to start a transmission
//     tx_done    UART TX -> loader   1-cycle pulse, transmission finished
//     mem_we     loader  -> progmem  write strobe, high for exactly one cycle
//     mem_addr   loader  -> progmem  write address (holds when mem_we is low)
//     mem_wdata  loader  -> progmem  write data
//
//   Handshake semantics: every strobe on this bus is a single-cycle pulse with
//   no ready/backpressure. A qualifier (rx_valid, tx_send, tx_done, mem_we)
//   high on a rising clk edge means its data is valid on that same edge. The
//   receiver must take the data then; it is not held or repeated.
//
//   Modports
//     master  the loader side (drives tx_* and mem_*)
//     slave   the UART/progmem side (drives rx_* and tx_done)
// ---------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              tx_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_done,
        output tx_data,
        output tx_send,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output tx_done,
        input  tx_data,
        input  tx_send,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Boot-load controller between the UART RX/TX pair and program memory.
//   Accepts a framed upload  START, LEN, LEN data bytes, XOR checksum,
//   writes every data byte into progmem, replies ACK or NAK over UART TX and
//   keeps the CPU in reset until a frame has been accepted.
//
//   Ports
//     clk        system clock
//     rst        synchronous, active-high reset
//     bus        prog_loader_if.master: rx byte stream, tx request/done,
//                progmem write port
//     cpu_rst_o  CPU reset, active-high; low only in RUN
//     loading_o  high while a frame is in progress (LEN .. WAIT_TX)
//     err_o      sticky: last frame was NAKed or timed out; cleared by START
//     state_o    current FSM state (debug):
//                0 IDLE, 1 LEN, 2 DATA, 3 CSUM, 4 WAIT_TX, 5 RUN
//
//   Parameters
//     ADDR_W      progmem address width, must be >= 8
//     START_BYTE  frame start marker
//     ACK_BYTE    reply when the checksum matches
//     NAK_BYTE    reply when the checksum does not match
//     TIMEOUT     max clk cycles without a byte while inside a frame
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int         ADDR_W     = 8,
    parameter logic [7:0] START_BYTE = 8'hA5,
    parameter logic [7:0] ACK_BYTE   = 8'h06,
    parameter logic [7:0] NAK_BYTE   = 8'h15,
    parameter int         TIMEOUT    = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus,
    output logic          cpu_rst_o,
    output logic          loading_o,
    output logic          err_o,
    output logic [2:0]    state_o
);

    // Enough bits to count up to TIMEOUT-1 idle cycles.
    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_DATA    = 3'd2,
        S_CSUM    = 3'd3,
        S_WAIT_TX = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Frame datapath.
    logic [ADDR_W-1:0] cnt_q, cnt_d;       // next write address, wraps mod 2^ADDR_W
    logic [8:0]        rem_q, rem_d;       // data bytes still expected (1..256)
    logic [7:0]        csum_q, csum_d;     // running XOR of data bytes
    logic [IDLE_W-1:0] idle_q, idle_d;     // idle cycles since the last byte

    // Registered outputs.
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              tx_send_q, tx_send_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              loading_q, loading_d;
    logic              err_q, err_d;

    logic is_start;
    logic in_frame;
    logic timeout_hit;
    logic csum_ok;

    assign is_start    = bus.rx_valid && (bus.rx_data == START_BYTE);
    assign in_frame    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    // Fires on the TIMEOUT-th consecutive cycle without a byte.
    assign timeout_hit = in_frame && !bus.rx_valid && (idle_q == IDLE_LAST);
    assign csum_ok     = (bus.rx_data == csum_q);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_start) state_d = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid)     state_d = S_DATA;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (rem_q == 9'd1) state_d = S_CSUM;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_CSUM: begin
                if (bus.rx_valid)     state_d = S_WAIT_TX;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_WAIT_TX: begin
                // err_q was set in CSUM exactly when the reply was a NAK.
                if (bus.tx_done) state_d = err_q ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (is_start) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output and datapath next-values
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we_d    = 1'b0;
        tx_send_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        idle_d      = '0;

        // Derived from the next state so the registered value lines up with
        // the state: cpu_rst drops on the cycle RUN is entered and rises on
        // the cycle after a reload START.
        cpu_rst_d = (state_d != S_RUN);
        loading_d = (state_d == S_LEN) || (state_d == S_DATA) ||
                    (state_d == S_CSUM) || (state_d == S_WAIT_TX);

        if (in_frame) begin
            if (bus.rx_valid) idle_d = '0;
            else              idle_d = idle_q + 1'b1;
            if (timeout_hit)  err_d  = 1'b1;
        end

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (is_start) err_d = 1'b0;
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    // LEN of 0 encodes a full 256-byte block.
                    rem_d  = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                    cnt_d  = '0;
                    csum_d = 8'h00;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = bus.rx_data;
                    csum_d      = csum_q ^ bus.rx_data;
                    cnt_d       = cnt_q + 1'b1;
                    rem_d       = rem_q - 9'd1;
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    tx_send_d = 1'b1;
                    tx_data_d = csum_ok ? ACK_BYTE : NAK_BYTE;
                    err_d     = !csum_ok;
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            tx_send_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            cpu_rst_q   <= 1'b1;
            loading_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= 9'd0;
            csum_q      <= 8'h00;
            idle_q      <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
            cpu_rst_q   <= cpu_rst_d;
            loading_q   <= loading_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.tx_data   = tx_data_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign loading_o     = loading_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader. A frame-level model (mode, remaining
//   count, checksum) is updated as each byte is driven; it queues the
//   expected progmem writes and TX replies and tracks cpu_rst/err/loading.
//   A negedge compare process checks the DUT against it every cycle, and the
//   main flow adds literal checks on memory contents and final state.
// ---------------------------------------------------------------------------
module tb_prog_loader;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 40;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd5;

    localparam int M_IDLE = 0;
    localparam int M_LEN  = 1;
    localparam int M_DATA = 2;
    localparam int M_CSUM = 3;
    localparam int M_WAIT = 4;
    localparam int M_RUN  = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();
    logic       cpu_rst;
    logic       loading;
    logic       err;
    logic [2:0] state;

    prog_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cpu_rst_o(cpu_rst),
        .loading_o(loading),
        .err_o    (err),
        .state_o  (state)
    );

    // ---------------- model / scoreboard ----------------
    logic [15:0] exp_q[$];      // expected writes {addr, data}
    logic [7:0]  exp_tx_q[$];   // expected TX reply bytes
    logic [7:0]  mem_img[256];  // progmem as written by the DUT
    logic [7:0]  last_tx;
    logic [15:0] wr_w;
    logic [7:0]  tx_w;

    int       mode;
    int       m_rem;
    int       m_cnt;
    logic [7:0] m_csum;
    logic     m_ack;
    logic     exp_cpu_rst;
    logic     exp_err;
    logic     exp_loading;
    logic     cmp_en;
    logic     status_en;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    assign exp_loading = (mode == M_LEN) || (mode == M_DATA) ||
                         (mode == M_CSUM) || (mode == M_WAIT);

    // Frame-level model: apply one received byte.
    task automatic model_byte(input logic [7:0] b);
        case (mode)
            M_IDLE, M_RUN: begin
                if (b == 8'hA5) begin
                    if (mode == M_RUN) exp_cpu_rst = 1'b1;
                    exp_err = 1'b0;
                    mode = M_LEN;
                end
            end
            M_LEN: begin
                m_rem  = (b == 8'h00) ? 256 : int'(b);
                m_cnt  = 0;
                m_csum = 8'h00;
                mode   = M_DATA;
            end
            M_DATA: begin
                exp_q.push_back({8'(m_cnt), b});
                m_csum = m_csum ^ b;
                m_cnt  = (m_cnt + 1) % 256;
                m_rem  = m_rem - 1;
                if (m_rem == 0) mode = M_CSUM;
            end
            M_CSUM: begin
                m_ack = (b == m_csum);
                exp_tx_q.push_back(m_ack ? 8'h06 : 8'h15);
                if (!m_ack) exp_err = 1'b1;
                mode = M_WAIT;
            end
            default: begin
            end
        endcase
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_we: unexpected write %0h@%0h", bus.mem_wdata, bus.mem_addr);
                end else begin
                    wr_w = exp_q.pop_front();
                    chk("mem_write", {bus.mem_addr, bus.mem_wdata}, {16'h0, wr_w});
                end
                mem_img[bus.mem_addr] = bus.mem_wdata;
            end
            if (bus.tx_send) begin
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_send: unexpected reply %0h", bus.tx_data);
                end else begin
                    tx_w = exp_tx_q.pop_front();
                    chk("tx_data", bus.tx_data, tx_w);
                end
                last_tx = bus.tx_data;
            end
            chk("cpu_rst", cpu_rst, exp_cpu_rst);
            if (status_en) begin
                chk("err", err, exp_err);
                chk("loading", loading, exp_loading);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap = 2);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step(1);
        bus.rx_valid = 1'b0;
        model_byte(b);
        step(gap);
    endtask

    task automatic done_pulse();
        bus.tx_done = 1'b1;
        step(1);
        bus.tx_done = 1'b0;
        if (mode == M_WAIT) begin
            mode = m_ack ? M_RUN : M_IDLE;
            if (m_ack) exp_cpu_rst = 1'b0;
        end
    endtask

    task automatic reply_tx();
        step(3);
        chk("tx_reply_seen", exp_tx_q.size(), 0);
        done_pulse();
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_done  = 1'b0;
        mode         = M_IDLE;
        m_rem        = 0;
        m_cnt        = 0;
        m_csum       = 8'h00;
        m_ack        = 1'b0;
        exp_cpu_rst  = 1'b1;
        exp_err      = 1'b0;
        cmp_en       = 1'b0;
        status_en    = 1'b1;
        last_tx      = 8'h00;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cpu_rst", cpu_rst, 1);
        chk("rst mem_we", bus.mem_we, 0);
        chk("rst tx_send", bus.tx_send, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst tx_data", bus.tx_data, 0);
        chk("rst loading", loading, 0);
        chk("rst err", err, 0);
        chk("rst state", state, ST_IDLE);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        step(2);

        // tx_done outside WAIT_TX is ignored; non-start byte ignored in IDLE
        done_pulse();
        send_byte(8'h3C);

        // NAK frame: A5,02,10,20,FF (10^20=30)
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hFF);
        reply_tx();
        @(negedge clk);
        chk("nak state", state, ST_IDLE);
        chk("nak err", err, 1);
        chk("nak cpu_rst", cpu_rst, 1);
        chk("nak tx", last_tx, 8'h15);
        chk("nak mem1", mem_img[1], 8'h20);
        @(posedge clk);
        #1;

        // Timeout: A5,02,10 then silence
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10, 0);
        status_en = 1'b0;
        step(TIMEOUT - 1);
        @(negedge clk);
        chk("pre-timeout loading", loading, 1);
        chk("pre-timeout err", err, 0);
        @(posedge clk);
        #1;
        mode      = M_IDLE;
        exp_err   = 1'b1;
        status_en = 1'b1;
        @(negedge clk);
        chk("timeout state", state, ST_IDLE);
        chk("timeout err", err, 1);
        chk("timeout kept byte", mem_img[0], 8'h10);
        @(posedge clk);
        #1;
        step(3);

        // ACK frame: A5,03,11,22,33,00 plus a dropped byte in WAIT_TX
        send_byte(8'hA5);
        @(negedge clk);
        chk("start clears err", err, 0);
        @(posedge clk);
        #1;
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h00);
        send_byte(8'hA5);
        reply_tx();
        @(negedge clk);
        chk("ack cpu_rst", cpu_rst, 0);
        chk("ack state", state, ST_RUN);
        chk("ack tx", last_tx, 8'h06);
        chk("ack mem0", mem_img[0], 8'h11);
        chk("ack mem1", mem_img[1], 8'h22);
        chk("ack mem2", mem_img[2], 8'h33);
        @(posedge clk);
        #1;

        // RUN: ignored inputs, then reload A5,01,7E,7E
        done_pulse();
        send_byte(8'h33);
        send_byte(8'hA5, 0);
        @(negedge clk);
        chk("reload cpu_rst", cpu_rst, 1);
        chk("reload loading", loading, 1);
        @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(8'h7E);
        reply_tx();
        @(negedge clk);
        chk("reload run", cpu_rst, 0);
        chk("reload mem0", mem_img[0], 8'h7E);
        chk("reload tx", last_tx, 8'h06);
        @(posedge clk);
        #1;

        // 256-byte frame, data i at addr i, one gap just under the timeout
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i), (i == 100) ? TIMEOUT - 1 : 1);
        send_byte(8'h00);
        reply_tx();
        @(negedge clk);
        chk("full cpu_rst", cpu_rst, 0);
        chk("full mem_addr", bus.mem_addr, 8'hFF);
        chk("full mem100", mem_img[100], 8'h64);
        chk("full memA5", mem_img[165], 8'hA5);
        chk("full mem255", mem_img[255], 8'hFF);
        @(posedge clk);
        #1;

        // Reset during DATA; the byte on the reset edge must not be written
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h03;
        rst          = 1'b1;
        step(1);
        bus.rx_valid = 1'b0;
        rst          = 1'b0;
        mode         = M_IDLE;
        exp_cpu_rst  = 1'b1;
        exp_err      = 1'b0;
        @(negedge clk);
        chk("midrst state", state, ST_IDLE);
        chk("midrst mem_we", bus.mem_we, 0);
        chk("midrst cpu_rst", cpu_rst, 1);
        chk("midrst loading", loading, 0);
        chk("midrst mem_addr", bus.mem_addr, 0);
        @(posedge clk);
        #1;
        step(4);

        chk("writes drained", exp_q.size(), 0);
        chk("replies drained", exp_tx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
